alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Micro-sequencer that owns the 8-bit combinational ALU (op 00 ADD, 01 NAND, 10 NOT x, 11 zero). It accepts high-level commands over a valid/ready handshake and runs one ALU pass per clock. It builds AND, SUB, OR and 8-bit MUL from ALU primitives, using internal temporaries. The result is returned over a valid/ready output handshake. It sits between the CPU control unit and the ALU instance, and is the only driver of the ALU inputs.

Parameters:
MUL_EN, 1, when 0 the MUL opcode is treated as reserved.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  command opcode, see Behaviour
cmd_a  input  8  operand A
cmd_b  input  8  operand B
alu_x  output  8  to ALU x_in
alu_y  output  8  to ALU y_in
alu_op  output  2  to ALU op_in
alu_z  input  8  from ALU z_out, combinational same cycle
res_valid  output  1  result present
res_ready  input  1  consumer accepts result
res_data  output  8  result
busy  output  1  high in EXEC or DONE

Behaviour:
- States: IDLE, EXEC, DONE.
- Registers:
  - A, B, OP: latched command.
  - T, U: 8-bit temporaries.
  - step: 4-bit pass counter.
  - R: result.
- Reset (async, any state, including mid-command):
  - Go to IDLE; step, A, B, OP, T, U and R all cleared.
  - Outputs: cmd_ready=1, res_valid=0, res_data=0, busy=0, alu_x=0, alu_y=0, alu_op=11.
- cmd_ready is 1 only in IDLE. A command is taken on the edge where cmd_valid&&cmd_ready: latch A, B, OP; step=0; T=0; U=0; go to EXEC. cmd_* is ignored in other states.
- EXEC:
  - Each cycle drives alu_x/alu_y/alu_op per the table below.
  - On the clock edge alu_z is written to the destination and step increments.
  - After the last pass, alu_z goes to R and the state becomes DONE.
- Pass table (pass: x, y, op -> destination):
  - 000 ADD: s0 A,B,00 -> R.
  - 001 NAND: s0 A,B,01 -> R.
  - 010 NOT: s0 A,0,10 -> R.
  - 011 AND: s0 A,B,01 -> T; s1 T,0,10 -> R.
  - 100 SUB (A-B mod 256): s0 B,0,10 -> T; s1 A,T,00 -> T; s2 T,1,00 -> R.
  - 101 OR: s0 A,0,10 -> T; s1 B,0,10 -> U; s2 T,U,01 -> R.
  - 110 MUL (low 8 bits of A*B): 16 passes, for i=7 down to 0:
    - Even pass: T,T,00 -> T (double).
    - Odd pass: T,(B[i]?A:0),00 -> T.
    - Pass 15 writes R.
  - 111 or MUL with MUL_EN=0: s0 0,0,11 -> R.
- Pass count P: 1, 1, 1, 2, 3, 3, 16, 1 (in opcode order).
- Latency: handshake in cycle c gives EXEC in cycles c+1..c+P and res_valid=1 from cycle c+1+P.
- Arithmetic: all adds are mod 256 and carry is discarded.
- DONE:
  - res_valid=1 and res_data=R, both held stable until res_valid&&res_ready.
  - On that edge: go to IDLE, res_valid=0. res_data keeps R until the next result is written.
  - No new command can be accepted in the same cycle; the earliest acceptance is the following cycle.
- In IDLE and DONE: alu_x=0, alu_y=0, alu_op=11.
- All outputs are registered or decoded from the state/step registers only; there is no combinational path from cmd_* or res_ready to any output.

Test Plan:
- Reset, then ADD A=200 B=100 handshake in cycle 0 -> alu_op=00 in cycle 1; res_valid=1, res_data=0x2C in cycle 2; res_ready=1 returns to IDLE and cmd_ready=1 in cycle 3.
- SUB A=5 B=7 -> three EXEC cycles with alu_op 10,00,00; res_data=0xFE in cycle 4. Also SUB A=7 B=5 -> 0x02.
- OR A=0xA0 B=0x05 -> 0xA5. AND A=0xF0 B=0x3C -> 0x30. NAND A=0xFF B=0xFF -> 0x00. NOT A=0x0F -> 0xF0. op 111 -> 0x00.
- MUL A=13 B=11 -> 0x8F with res_valid in cycle 17. MUL A=16 B=17 -> 0x10. MUL A=0xFF B=0 -> 0x00. With MUL_EN=0, MUL A=3 B=3 -> 0x00 after 1 pass.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_data stable, cmd_ready=0, and a cmd_valid pulse with a different command is ignored. Then res_ready=1 -> IDLE, and the next command is accepted the following cycle.
- Reset mid-operation: assert rst_n=0 during MUL step 6 -> immediately IDLE, res_valid=0, alu_op=11. After release, ADD 1+1 -> 0x02 with normal latency, unaffected by old T.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - micro-sequencer building AND/SUB/OR/MUL from a 4-op ALU
// Commands run one ALU pass per clock; ALU drive values are registered a cycle ahead.
module alu_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  state_t      r_state;
  logic [7:0]  r_a, r_b, r_t, r_u, r_r;
  logic [2:0]  r_op;
  logic [3:0]  r_step;

  logic [2:0]  w_cmd_op;
  logic        w_last;
  logic [7:0]  w_t_nxt, w_u_nxt;
  logic [17:0] w_drv_first, w_drv_next;

  function automatic logic [3:0] last_step(input logic [2:0] op);
    case (op)
      3'd3:        last_step = 4'd1;
      3'd4, 3'd5:  last_step = 4'd2;
      3'd6:        last_step = 4'd15;
      default:     last_step = 4'd0;
    endcase
  endfunction

  // Returns {x, y, op} for a given pass of a given command.
  function automatic logic [17:0] pass_drive(input logic [2:0] op, input logic [3:0] step,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] t, input logic [7:0] u);
    logic [7:0] x, y;
    logic [1:0] f;
    logic [2:0] bit_idx;
    x = 8'd0;
    y = 8'd0;
    f = ALU_ZERO;
    bit_idx = 3'd7 - step[3:1];
    case (op)
      3'd0: begin x = a; y = b; f = ALU_ADD; end
      3'd1: begin x = a; y = b; f = ALU_NAND; end
      3'd2: begin x = a; f = ALU_NOT; end
      3'd3: begin
        if (step == 4'd0) begin x = a; y = b; f = ALU_NAND; end
        else begin x = t; f = ALU_NOT; end
      end
      3'd4: begin
        case (step)
          4'd0:    begin x = b; f = ALU_NOT; end
          4'd1:    begin x = a; y = t; f = ALU_ADD; end
          default: begin x = t; y = 8'd1; f = ALU_ADD; end
        endcase
      end
      3'd5: begin
        case (step)
          4'd0:    begin x = a; f = ALU_NOT; end
          4'd1:    begin x = b; f = ALU_NOT; end
          default: begin x = t; y = u; f = ALU_NAND; end
        endcase
      end
      3'd6: begin
        // MSB-first shift-and-add: even passes double, odd passes add A if B bit set.
        x = t;
        f = ALU_ADD;
        if (step[0]) y = b[bit_idx] ? a : 8'd0;
        else         y = t;
      end
      default: ;
    endcase
    pass_drive = {x, y, f};
  endfunction

  always_comb begin
    w_cmd_op = cmd_op;
    if (cmd_op == 3'd6 && !MUL_EN) w_cmd_op = 3'd7;
    w_last  = (r_step == last_step(r_op));
    w_t_nxt = r_t;
    w_u_nxt = r_u;
    if (!w_last) begin
      if (r_op == 3'd5 && r_step == 4'd1) w_u_nxt = alu_z;
      else                                w_t_nxt = alu_z;
    end
    w_drv_first = pass_drive(w_cmd_op, 4'd0, cmd_a, cmd_b, 8'd0, 8'd0);
    w_drv_next  = pass_drive(r_op, r_step + 4'd1, r_a, r_b, w_t_nxt, w_u_nxt);
  end

  assign res_data = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_op      <= 3'd0;
      r_t       <= 8'd0;
      r_u       <= 8'd0;
      r_r       <= 8'd0;
      r_step    <= 4'd0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      alu_x     <= 8'd0;
      alu_y     <= 8'd0;
      alu_op    <= ALU_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a                     <= cmd_a;
            r_b                     <= cmd_b;
            r_op                    <= w_cmd_op;
            r_step                  <= 4'd0;
            r_t                     <= 8'd0;
            r_u                     <= 8'd0;
            r_state                 <= S_EXEC;
            cmd_ready               <= 1'b0;
            busy                    <= 1'b1;
            {alu_x, alu_y, alu_op}  <= w_drv_first;
          end
        end
        S_EXEC: begin
          if (w_last) begin
            r_r                     <= alu_z;
            r_state                 <= S_DONE;
            res_valid               <= 1'b1;
            {alu_x, alu_y, alu_op}  <= {8'd0, 8'd0, ALU_ZERO};
          end else begin
            r_t                     <= w_t_nxt;
            r_u                     <= w_u_nxt;
            r_step                  <= r_step + 4'd1;
            {alu_x, alu_y, alu_op}  <= w_drv_next;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state   <= S_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
// Provides the combinational ALU beside each sequencer instance.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;

  logic       cmd_valid, cmd_ready, res_valid, res_ready, busy;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b, alu_x, alu_y, alu_z, res_data;
  logic [1:0] alu_op;

  logic       m0_cmd_valid, m0_cmd_ready, m0_res_valid, m0_res_ready, m0_busy;
  logic [2:0] m0_cmd_op;
  logic [7:0] m0_cmd_a, m0_cmd_b, m0_alu_x, m0_alu_y, m0_alu_z, m0_res_data;
  logic [1:0] m0_alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  alu_sequencer #(.MUL_EN(1'b0)) dut_m0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(m0_cmd_valid), .cmd_ready(m0_cmd_ready), .cmd_op(m0_cmd_op),
    .cmd_a(m0_cmd_a), .cmd_b(m0_cmd_b),
    .alu_x(m0_alu_x), .alu_y(m0_alu_y), .alu_op(m0_alu_op), .alu_z(m0_alu_z),
    .res_valid(m0_res_valid), .res_ready(m0_res_ready), .res_data(m0_res_data), .busy(m0_busy)
  );

  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
    case (op)
      2'b00:   alu = x + y;
      2'b01:   alu = ~(x & y);
      2'b10:   alu = ~x;
      default: alu = 8'd0;
    endcase
  endfunction

  assign alu_z    = alu(alu_x, alu_y, alu_op);
  assign m0_alu_z = alu(m0_alu_x, m0_alu_y, m0_alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, track the ALU op history, then drain the result.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp,
                        input int exp_lat, input logic [5:0] exp_hist);
    int lat;
    logic [5:0] hist;
    chk({tag, " ready"}, cmd_ready, 1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat  = 1;
    hist = {4'b1111, alu_op};
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!res_valid) hist = {hist[3:0], alu_op};
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, res_data, exp);
    chk({tag, " alu ops"}, hist, exp_hist);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, " back to idle"}, {cmd_ready, res_valid, busy, res_data}, {3'b100, exp});
  endtask

  task automatic m0_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int lat;
    m0_cmd_op = op; m0_cmd_a = a; m0_cmd_b = b; m0_cmd_valid = 1'b1;
    @(posedge clk); #1;
    m0_cmd_valid = 1'b0;
    lat = 1;
    while (!m0_res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, m0_res_data, exp);
    m0_res_ready = 1'b1;
    @(posedge clk); #1;
    m0_res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0; res_ready = 1'b0;
    m0_cmd_valid = 1'b0; m0_cmd_op = 3'd0; m0_cmd_a = 8'd0; m0_cmd_b = 8'd0; m0_res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {cmd_ready, res_valid, busy, res_data, alu_x, alu_y, alu_op},
        {3'b100, 8'd0, 8'd0, 8'd0, 2'b11});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd("ADD 200+100", 3'd0, 8'd200, 8'd100, 8'h2C, 2, 6'b111100);
    do_cmd("SUB 5-7",     3'd4, 8'd5,   8'd7,   8'hFE, 4, 6'b100000);
    do_cmd("SUB 7-5",     3'd4, 8'd7,   8'd5,   8'h02, 4, 6'b100000);
    do_cmd("OR",          3'd5, 8'hA0,  8'h05,  8'hA5, 4, 6'b101001);
    do_cmd("AND",         3'd3, 8'hF0,  8'h3C,  8'h30, 3, 6'b110110);
    do_cmd("NAND",        3'd1, 8'hFF,  8'hFF,  8'h00, 2, 6'b111101);
    do_cmd("NOT",         3'd2, 8'h0F,  8'h00,  8'hF0, 2, 6'b111110);
    do_cmd("ADD 3+3",     3'd0, 8'd3,   8'd3,   8'h06, 2, 6'b111100);
    do_cmd("ZERO op7",    3'd7, 8'h12,  8'h34,  8'h00, 2, 6'b111111);
    do_cmd("MUL 13*11",   3'd6, 8'd13,  8'd11,  8'h8F, 17, 6'b000000);
    do_cmd("MUL 16*17",   3'd6, 8'd16,  8'd17,  8'h10, 17, 6'b000000);
    do_cmd("MUL FF*0",    3'd6, 8'hFF,  8'h00,  8'h00, 17, 6'b000000);

    m0_cmd("M0 ADD 3+3",  3'd0, 8'd3, 8'd3, 8'h06, 2);
    m0_cmd("M0 MUL 3*3",  3'd6, 8'd3, 8'd3, 8'h00, 2);

    // Backpressure: hold the result, poke a different command, it must be ignored.
    cmd_op = 3'd0; cmd_a = 8'd1; cmd_b = 8'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2); cmd_op = 3'd2; cmd_a = 8'h55;
      chk("bp hold", {cmd_ready, res_valid, busy, res_data}, {3'b011, 8'h03});
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("bp after hold", {cmd_ready, res_valid, res_data}, {2'b01, 8'h03});
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    do_cmd("ADD after bp", 3'd0, 8'd10, 8'd20, 8'd30, 2, 6'b111100);

    // Reset during MUL pass 6.
    cmd_op = 3'd6; cmd_a = 8'd13; cmd_b = 8'd11; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid-mul busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-mul reset", {cmd_ready, res_valid, busy, res_data, alu_x, alu_y, alu_op},
        {3'b100, 8'd0, 8'd0, 8'd0, 2'b11});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd("ADD 1+1 after rst", 3'd0, 8'd1, 8'd1, 8'h02, 2, 6'b111100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
